spi_slave_fifo: RTL

//  Parametrised Wishbone SPI slave, successor of the single-register slave. SPI pins are

---
 rtl/spi_slave_fifo.sv | 313 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_fifo.sv
// Wishbone SPI slave with an RX FIFO, a TX holding register and sticky overrun/underrun flags.
// Optional LSB-first shifting (CTRL[11]) is compiled in when SPI_SLV_LSB_FIRST_EN is defined.
module spi_slave_fifo #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned RX_DEPTH = 8,
    parameter int unsigned SS_W     = 32
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    input  logic [4:0]      wb_adr_i,
    input  logic [31:0]     wb_dat_i,
    output logic [31:0]     wb_dat_o,
    input  logic [3:0]      wb_sel_i,
    input  logic            wb_we_i,
    input  logic            wb_stb_i,
    input  logic            wb_cyc_i,
    output logic            wb_ack_o,
    output logic            wb_err_o,
    output logic            wb_int_o,
    input  logic [SS_W-1:0] ss_pad_i,
    input  logic            sclk_pad_i,
    input  logic            mosi_pad_i,
    output logic            miso_pad_o
);

    localparam int unsigned CNT_W  = $clog2(DATA_W + 1);
    localparam int unsigned PTR_W  = $clog2(RX_DEPTH);
    localparam int unsigned FILL_W = PTR_W + 1;

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StPush} state_e;

    // Bus decode
    logic [2:0] adr;
    logic       req, mapped, wr_req, rd_req;
    logic       ctrl_wr, stat_wr, hold_wr, pop_req;

    assign adr     = wb_adr_i[4:2];
    assign req     = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
    assign mapped  = (adr == 3'd0) | (adr == 3'd1) | (adr == 3'd4);
    assign wr_req  = req & mapped & wb_we_i;
    assign rd_req  = req & mapped & ~wb_we_i;
    assign ctrl_wr = wr_req & (adr == 3'd4);
    assign stat_wr = wr_req & (adr == 3'd1);
    assign hold_wr = wr_req & (adr == 3'd0);
    assign pop_req = rd_req & (adr == 3'd0);

    logic unused_bits;
    assign unused_bits = ^{wb_adr_i[1:0], wb_sel_i[3:2]};

    // Control register
    logic [6:0] char_len_q;
    logic       rx_neg_q, tx_neg_q, ie_q, en_q;
    logic       lsb_first;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            char_len_q <= '0;
            rx_neg_q   <= 1'b0;
            tx_neg_q   <= 1'b0;
            ie_q       <= 1'b0;
            en_q       <= 1'b0;
        end else if (ctrl_wr) begin
            if (wb_sel_i[0]) char_len_q <= wb_dat_i[6:0];
            if (wb_sel_i[1]) begin
                rx_neg_q <= wb_dat_i[9];
                tx_neg_q <= wb_dat_i[10];
                ie_q     <= wb_dat_i[12];
                en_q     <= wb_dat_i[13];
            end
        end
    end

`ifdef SPI_SLV_LSB_FIRST_EN
    logic lsb_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            lsb_q <= 1'b0;
        end else if (ctrl_wr && wb_sel_i[1]) begin
            lsb_q <= wb_dat_i[11];
        end
    end

    assign lsb_first = lsb_q;
`else
    assign lsb_first = 1'b0;
`endif

    logic [CNT_W-1:0] len_eff, shamt;

    assign len_eff = ((char_len_q == 7'd0) || (char_len_q > 7'(DATA_W))) ?
                     CNT_W'(DATA_W) : CNT_W'(char_len_q);
    assign shamt   = CNT_W'(DATA_W) - len_eff;

    // Pad synchronisers; sclk keeps a third stage for edge detection
    logic [2:0] sclk_sync;
    logic [1:0] mosi_sync, sel_sync;
    logic       sel_s, mosi_s, rise, fall, rx_edge, tx_edge;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            sel_sync  <= '0;
        end else begin
            sclk_sync <= {sclk_sync[1:0], sclk_pad_i};
            mosi_sync <= {mosi_sync[0], mosi_pad_i};
            sel_sync  <= {sel_sync[0], ~&ss_pad_i};
        end
    end

    assign sel_s   = sel_sync[1];
    assign mosi_s  = mosi_sync[1];
    assign rise    = sclk_sync[1] & ~sclk_sync[2];
    assign fall    = ~sclk_sync[1] & sclk_sync[2];
    assign rx_edge = rx_neg_q ? fall : rise;
    assign tx_edge = tx_neg_q ? fall : rise;

    // Shift engine
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d, tx_word, rx_word;
    logic              miso_q, miso_d, load_zero_q, load_zero_d;
    logic              hold_take, push_req, udr_set;
    logic [DATA_W-1:0] hold_q;
    logic              hold_full_q;

    assign tx_word = hold_full_q ? hold_q : '0;
    assign rx_word = lsb_first ? (rx_shift_q >> shamt) : rx_shift_q;

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        miso_d      = miso_q;
        load_zero_d = load_zero_q;
        hold_take   = 1'b0;
        push_req    = 1'b0;
        udr_set     = 1'b0;
        case (state_q)
            StIdle: begin
                miso_d = 1'b0;
                if (sel_s && en_q) state_d = StLoad;
            end
            StLoad: begin
                hold_take   = hold_full_q;
                load_zero_d = ~hold_full_q;
                bitcnt_d    = '0;
                rx_shift_d  = '0;
                // MSB-first characters are left-aligned so the head bit is always the top bit
                tx_shift_d  = lsb_first ? tx_word : (tx_word << shamt);
                miso_d      = lsb_first ? tx_shift_d[0] : tx_shift_d[DATA_W-1];
                state_d     = StShift;
            end
            StShift: begin
                if (!sel_s) begin
                    state_d = StIdle;
                end else begin
                    // The first bit is already on miso from LOAD; hold it until sampled
                    if (tx_edge && ((bitcnt_q != '0) || rx_edge)) begin
                        tx_shift_d = lsb_first ? (tx_shift_q >> 1) : (tx_shift_q << 1);
                        miso_d     = lsb_first ? tx_shift_d[0] : tx_shift_d[DATA_W-1];
                    end
                    if (rx_edge) begin
                        if (lsb_first) begin
                            rx_shift_d             = rx_shift_q >> 1;
                            rx_shift_d[DATA_W-1]   = mosi_s;
                        end else begin
                            rx_shift_d    = rx_shift_q << 1;
                            rx_shift_d[0] = mosi_s;
                        end
                        bitcnt_d = bitcnt_q + 1'b1;
                        if ((bitcnt_q == '0) && load_zero_q) udr_set = 1'b1;
                        if (bitcnt_d == len_eff) state_d = StPush;
                    end
                end
            end
            StPush: begin
                push_req = 1'b1;
                state_d  = sel_s ? StLoad : StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (!en_q) state_d = StIdle;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= StIdle;
            bitcnt_q    <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            miso_q      <= 1'b0;
            load_zero_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            miso_q      <= miso_d;
            load_zero_q <= load_zero_d;
        end
    end

    assign miso_pad_o = miso_q;

    // TX holding register; a bus write in the same cycle as LOAD refills it
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else if (hold_wr) begin
            hold_q      <= wb_dat_i[DATA_W-1:0];
            hold_full_q <= 1'b1;
        end else if (hold_take) begin
            hold_full_q <= 1'b0;
        end
    end

    // RX FIFO
    logic [DATA_W-1:0] mem [RX_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [FILL_W-1:0] fill_q;
    logic              fifo_empty, fifo_full, pop, push_ok, ovr_set;
    logic              ovr_q, udr_q, clr_ovr, clr_udr;

    assign fifo_empty = (fill_q == '0);
    assign fifo_full  = (fill_q == FILL_W'(RX_DEPTH));
    assign pop        = pop_req & ~fifo_empty;
    // A pop in the same cycle frees the slot the push needs
    assign push_ok    = push_req & (~fifo_full | pop);
    assign ovr_set    = push_req & fifo_full & ~pop;

    always_ff @(posedge wb_clk_i) begin
        if (push_ok) mem[wr_ptr_q] <= rx_word;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop})
                2'b10:   fill_q <= fill_q + 1'b1;
                2'b01:   fill_q <= fill_q - 1'b1;
                default: fill_q <= fill_q;
            endcase
        end
    end

    // Sticky flags; a fresh event outranks a simultaneous clear
    assign clr_ovr = stat_wr & wb_sel_i[0] & wb_dat_i[3];
    assign clr_udr = stat_wr & wb_sel_i[0] & wb_dat_i[4];

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ovr_q <= 1'b0;
            udr_q <= 1'b0;
        end else begin
            ovr_q <= (ovr_q & ~clr_ovr) | ovr_set;
            udr_q <= (udr_q & ~clr_udr) | udr_set;
        end
    end

    // Read mux and bus response
    logic [31:0] status_word, ctrl_word, rdata;
    logic [7:0]  fill8;

    assign fill8 = 8'(fill_q);

    always_comb begin
        status_word       = '0;
        status_word[0]    = ~fifo_empty;
        status_word[1]    = fifo_full;
        status_word[2]    = ~hold_full_q;
        status_word[3]    = ovr_q;
        status_word[4]    = udr_q;
        status_word[5]    = sel_s;
        status_word[15:8] = fill8;
        ctrl_word         = '0;
        ctrl_word[6:0]    = char_len_q;
        ctrl_word[9]      = rx_neg_q;
        ctrl_word[10]     = tx_neg_q;
        ctrl_word[11]     = lsb_first;
        ctrl_word[12]     = ie_q;
        ctrl_word[13]     = en_q;
        case (adr)
            3'd0:    rdata = fifo_empty ? 32'd0 : 32'(mem[rd_ptr_q]);
            3'd1:    rdata = status_word;
            3'd4:    rdata = ctrl_word;
            default: rdata = 32'd0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
            wb_int_o <= 1'b0;
        end else begin
            wb_ack_o <= req & mapped;
            wb_err_o <= req & ~mapped;
            if (rd_req) wb_dat_o <= rdata;
            wb_int_o <= ie_q & (~fifo_empty | ovr_q | udr_q);
        end
    end

endmodule
